// File: rtl/davos_types.sv
// Shared networking types and constants for the davos receive path.
package davos_types;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } rx_filt_state_t;

endpackage

// File: rtl/rx_frame_buffer.sv
// Simple dual-port frame store with a registered, enabled read port (BRAM style).
module rx_frame_buffer #(
    parameter int EW    = 64,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [EW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [EW-1:0] rd_data
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // The read register doubles as the egress output stage, so it holds when not enabled.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/net_rx_frame_filter.sv
// Store-and-forward Ethernet RX filter: forwards only complete unicast/broadcast IPv4/ARP frames.
// Optional frame counters are built when RX_FILTER_STATS_EN is defined.
module net_rx_frame_filter
    import davos_types::*;
#(
    parameter int WIDTH     = 512,
    parameter int DEPTH     = 256,
    parameter int MAX_BEATS = 24
) (
    input  logic               net_clk,
    input  logic               net_rst,
    input  logic [47:0]        local_mac,
    input  logic [WIDTH-1:0]   s_axis_data,
    input  logic [WIDTH/8-1:0] s_axis_keep,
    input  logic               s_axis_last,
    input  logic               s_axis_valid,
    output logic               s_axis_ready,
    output logic [WIDTH-1:0]   m_axis_data,
    output logic [WIDTH/8-1:0] m_axis_keep,
    output logic               m_axis_last,
    output logic               m_axis_valid,
    input  logic               m_axis_ready,
    output logic [31:0]        stat_ok,
    output logic [31:0]        stat_drop_filter,
    output logic [31:0]        stat_drop_size,
    output logic [31:0]        stat_drop_ovf,
    output rx_filt_state_t     dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = WIDTH / 8;
    localparam int EW = WIDTH + KW + 1;
    localparam int CW = $clog2(MAX_BEATS + 1) + 1;

    // valid/ready: a beat transfers on any cycle where both are high; the egress
    // beat (data/keep/last) is held unchanged while m_axis_valid=1 and m_axis_ready=0.

    rx_filt_state_t state;
    logic [PW-1:0]  wr_ptr, commit_ptr, rd_ptr;
    logic [CW-1:0]  beat_cnt;
    logic [47:0]    dst_mac;
    logic [15:0]    eth_type;
    logic           beat, full, hdr_ok, runt, over, rd_en;
    logic           wr_en, commit, rollback;
    logic           ev_ok, ev_filt, ev_size, ev_ovf;
    logic [EW-1:0]  ram_q;

    assign s_axis_ready = !net_rst;
    assign beat         = s_axis_valid && s_axis_ready;
    assign full         = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign eth_type     = {s_axis_data[103:96], s_axis_data[111:104]};
    assign runt         = !s_axis_keep[13];
    assign over         = beat_cnt == CW'(MAX_BEATS);
    assign hdr_ok       = (dst_mac == local_mac || dst_mac == ETH_BCAST_MAC) &&
                          (eth_type == ETH_TYPE_IPV4 || eth_type == ETH_TYPE_ARP);
    assign dbg_state    = state;

    always_comb begin
        dst_mac = '0;
        for (int i = 0; i < 6; i++) dst_mac[47-8*i -: 8] = s_axis_data[8*i +: 8];
    end

    always_comb begin
        wr_en    = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        ev_ok    = 1'b0;
        ev_filt  = 1'b0;
        ev_size  = 1'b0;
        ev_ovf   = 1'b0;
        if (beat) begin
            case (state)
                IDLE: begin
                    if (runt)         ev_size = 1'b1;
                    else if (!hdr_ok) ev_filt = 1'b1;
                    else if (full)    ev_ovf  = 1'b1;
                    else begin
                        wr_en  = 1'b1;
                        commit = s_axis_last;
                        ev_ok  = s_axis_last;
                    end
                end
                PASS: begin
                    if (over) begin
                        ev_size  = 1'b1;
                        rollback = 1'b1;
                    end else if (full) begin
                        ev_ovf   = 1'b1;
                        rollback = 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        commit = s_axis_last;
                        ev_ok  = s_axis_last;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge net_clk) begin
        if (net_rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            beat_cnt   <= '0;
        end else begin
            if (wr_en)         wr_ptr <= wr_ptr + PW'(1);
            else if (rollback) wr_ptr <= commit_ptr;
            if (commit)        commit_ptr <= wr_ptr + PW'(1);
            if (rd_en)         rd_ptr <= rd_ptr + PW'(1);
            if (beat) begin
                case (state)
                    IDLE: begin
                        if (wr_en) begin
                            beat_cnt <= CW'(1);
                            state    <= s_axis_last ? IDLE : PASS;
                        end else begin
                            state    <= s_axis_last ? IDLE : DROP;
                        end
                    end
                    PASS: begin
                        if (wr_en) begin
                            beat_cnt <= beat_cnt + CW'(1);
                            if (s_axis_last) state <= IDLE;
                        end else begin
                            state <= s_axis_last ? IDLE : DROP;
                        end
                    end
                    DROP:    if (s_axis_last) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Read ahead into the output register whenever it is empty or being consumed.
    assign rd_en = (rd_ptr != commit_ptr) && (!m_axis_valid || m_axis_ready);

    always_ff @(posedge net_clk) begin
        if (net_rst)           m_axis_valid <= 1'b0;
        else if (rd_en)        m_axis_valid <= 1'b1;
        else if (m_axis_ready) m_axis_valid <= 1'b0;
    end

    rx_frame_buffer #(
        .EW    (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk     (net_clk),
        .rst     (net_rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data ({s_axis_last, s_axis_keep, s_axis_data}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

    assign {m_axis_last, m_axis_keep, m_axis_data} = ram_q;

`ifdef RX_FILTER_STATS_EN
    always_ff @(posedge net_clk) begin
        if (net_rst) begin
            stat_ok          <= '0;
            stat_drop_filter <= '0;
            stat_drop_size   <= '0;
            stat_drop_ovf    <= '0;
        end else begin
            if (ev_ok   && stat_ok          != '1) stat_ok          <= stat_ok + 32'd1;
            if (ev_filt && stat_drop_filter != '1) stat_drop_filter <= stat_drop_filter + 32'd1;
            if (ev_size && stat_drop_size   != '1) stat_drop_size   <= stat_drop_size + 32'd1;
            if (ev_ovf  && stat_drop_ovf    != '1) stat_drop_ovf    <= stat_drop_ovf + 32'd1;
        end
    end
`else
    logic unused_ev;
    assign unused_ev        = ^{ev_ok, ev_filt, ev_size, ev_ovf};
    assign stat_ok          = '0;
    assign stat_drop_filter = '0;
    assign stat_drop_size   = '0;
    assign stat_drop_ovf    = '0;
`endif

endmodule

// File: tb/tb_net_rx_frame_filter.sv
// Directed self-checking bench for net_rx_frame_filter (WIDTH=128, DEPTH=32, MAX_BEATS=24).
module tb_net_rx_frame_filter;
    import davos_types::*;

    localparam int WIDTH     = 128;
    localparam int DEPTH     = 32;
    localparam int MAX_BEATS = 24;
    localparam int KW        = WIDTH / 8;
    localparam int EW        = WIDTH + KW + 1;
    localparam logic [47:0] MY_MAC = 48'h000A_3501_0203;
`ifdef RX_FILTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             net_clk = 1'b0;
    logic             net_rst = 1'b1;
    logic [WIDTH-1:0] s_axis_data = '0;
    logic [KW-1:0]    s_axis_keep = '0;
    logic             s_axis_last = 1'b0;
    logic             s_axis_valid = 1'b0;
    logic             s_axis_ready;
    logic [WIDTH-1:0] m_axis_data;
    logic [KW-1:0]    m_axis_keep;
    logic             m_axis_last;
    logic             m_axis_valid;
    logic             m_axis_ready = 1'b1;
    logic [31:0]      stat_ok, stat_drop_filter, stat_drop_size, stat_drop_ovf;
    rx_filt_state_t   dbg_state;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 net_clk = ~net_clk;

    net_rx_frame_filter #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .net_clk          (net_clk),
        .net_rst          (net_rst),
        .local_mac        (MY_MAC),
        .s_axis_data      (s_axis_data),
        .s_axis_keep      (s_axis_keep),
        .s_axis_last      (s_axis_last),
        .s_axis_valid     (s_axis_valid),
        .s_axis_ready     (s_axis_ready),
        .m_axis_data      (m_axis_data),
        .m_axis_keep      (m_axis_keep),
        .m_axis_last      (m_axis_last),
        .m_axis_valid     (m_axis_valid),
        .m_axis_ready     (m_axis_ready),
        .stat_ok          (stat_ok),
        .stat_drop_filter (stat_drop_filter),
        .stat_drop_size   (stat_drop_size),
        .stat_drop_ovf    (stat_drop_ovf),
        .dbg_state        (dbg_state)
    );

    // Egress capture: a beat present at the negedge with ready high transfers on the next posedge.
    always @(negedge net_clk) begin
        if (!net_rst && m_axis_valid && m_axis_ready)
            got_q.push_back({m_axis_last, m_axis_keep, m_axis_data});
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] exp_stat(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [WIDTH-1:0] hdr_beat(input logic [47:0] dst, input logic [15:0] et,
                                                  input logic [7:0] tag);
        logic [WIDTH-1:0] d;
        for (int n = 0; n < KW; n++) d[8*n +: 8] = tag + 8'(n);
        for (int n = 0; n < 6; n++) d[8*n +: 8] = dst[47-8*n -: 8];
        d[103:96]  = et[15:8];
        d[111:104] = et[7:0];
        return d;
    endfunction

    function automatic logic [WIDTH-1:0] body_beat(input logic [7:0] tag, input int i);
        logic [WIDTH-1:0] d;
        for (int n = 0; n < KW; n++) d[8*n +: 8] = (n % 2 == 0) ? tag : 8'(i);
        return d;
    endfunction

    // Called at posedge+1; the beat transfers on the following posedge.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic [KW-1:0] k, input logic l);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        s_axis_keep  = k;
        s_axis_last  = l;
        @(posedge net_clk);
        #1;
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int nbeats,
                              input logic [7:0] tag, input bit pass);
        logic [WIDTH-1:0] d;
        logic [KW-1:0]    k;
        logic             l;
        for (int i = 0; i < nbeats; i++) begin
            d = (i == 0) ? hdr_beat(dst, et, tag) : body_beat(tag, i);
            l = (i == nbeats - 1);
            k = (l && i != 0) ? 16'h00FF : 16'hFFFF;
            if (pass) exp_q.push_back({l, k, d});
            send_beat(d, k, l);
        end
    endtask

    task automatic wait_drain(input int n, input int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            @(posedge net_clk);
            c++;
        end
        repeat (8) @(posedge net_clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        net_rst = 1'b1;
        repeat (3) @(posedge net_clk);
        #1;
        n_checks++;
        if (s_axis_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", s_axis_ready); else n_pass++;
        net_rst = 1'b0;
        @(posedge net_clk);
        #1;
        n_checks++;
        if (s_axis_ready !== 1'b1) $display("FAIL reset_ready_high: got %b want 1", s_axis_ready); else n_pass++;
        n_checks++;
        if (m_axis_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_axis_valid); else n_pass++;
        n_checks++;
        if ({m_axis_last, m_axis_keep, m_axis_data} !== '0)
            $display("FAIL reset_out: got %h want 0", {m_axis_last, m_axis_keep, m_axis_data}); else n_pass++;
        n_checks++;
        if ({stat_ok, stat_drop_filter, stat_drop_size, stat_drop_ovf} !== '0)
            $display("FAIL reset_stats: got %h want 0", {stat_ok, stat_drop_filter, stat_drop_size, stat_drop_ovf}); else n_pass++;
        n_checks++;
        if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
    endtask

    task automatic test_unicast();
        exp_q.delete();
        got_q.delete();
        m_axis_ready = 1'b1;
        send_frame(MY_MAC, ETH_TYPE_IPV4, 3, 8'h10, 1'b1);
        n_checks++;
        if (m_axis_valid !== 1'b0) $display("FAIL unicast_lat1: got valid %b want 0", m_axis_valid); else n_pass++;
        @(posedge net_clk);
        #1;
        n_checks++;
        if (m_axis_valid !== 1'b1) $display("FAIL unicast_lat2: got valid %b want 1", m_axis_valid); else n_pass++;
        wait_drain(exp_q.size(), 50);
        n_checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL unicast_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL unicast_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (stat_ok !== exp_stat(1)) $display("FAIL unicast_stat_ok: got %0d want %0d", stat_ok, exp_stat(1)); else n_pass++;
    endtask

    task automatic test_filter();
        exp_q.delete();
        got_q.delete();
        send_frame(ETH_BCAST_MAC, ETH_TYPE_ARP, 1, 8'h20, 1'b1);
        send_beat(hdr_beat(48'h000A_35FF_FFFF, 16'h86DD, 8'h30), 16'hFFFF, 1'b0);
        n_checks++;
        if (dbg_state !== DROP) $display("FAIL filter_state_drop: got %0d want %0d", dbg_state, DROP); else n_pass++;
        send_beat(body_beat(8'h30, 1), 16'h00FF, 1'b1);
        n_checks++;
        if (dbg_state !== IDLE) $display("FAIL filter_state_idle: got %0d want %0d", dbg_state, IDLE); else n_pass++;
        wait_drain(exp_q.size(), 50);
        n_checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL filter_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL filter_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (stat_drop_filter !== exp_stat(1))
            $display("FAIL filter_stat: got %0d want %0d", stat_drop_filter, exp_stat(1)); else n_pass++;
        n_checks++;
        if (stat_ok !== exp_stat(2)) $display("FAIL filter_stat_ok: got %0d want %0d", stat_ok, exp_stat(2)); else n_pass++;
    endtask

    task automatic test_oversize();
        exp_q.delete();
        got_q.delete();
        send_frame(MY_MAC, ETH_TYPE_IPV4, MAX_BEATS, 8'h40, 1'b1);
        send_frame(MY_MAC, ETH_TYPE_IPV4, MAX_BEATS + 1, 8'h50, 1'b0);
        send_frame(MY_MAC, ETH_TYPE_ARP, 2, 8'h60, 1'b1);
        wait_drain(exp_q.size(), 200);
        n_checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL oversize_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL oversize_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (stat_drop_size !== exp_stat(1))
            $display("FAIL oversize_stat: got %0d want %0d", stat_drop_size, exp_stat(1)); else n_pass++;
        n_checks++;
        if (stat_ok !== exp_stat(4)) $display("FAIL oversize_stat_ok: got %0d want %0d", stat_ok, exp_stat(4)); else n_pass++;
    endtask

    task automatic test_overflow();
        exp_q.delete();
        got_q.delete();
        m_axis_ready = 1'b0;
        for (int f = 0; f < 9; f++) send_frame(MY_MAC, ETH_TYPE_IPV4, 4, 8'h90 + 8'(f), f < 8);
        n_checks++;
        if (m_axis_valid !== 1'b1) $display("FAIL overflow_stall_valid: got %b want 1", m_axis_valid); else n_pass++;
        n_checks++;
        if ({m_axis_last, m_axis_keep, m_axis_data} !== exp_q[0])
            $display("FAIL overflow_stall_data: got %h want %h", {m_axis_last, m_axis_keep, m_axis_data}, exp_q[0]); else n_pass++;
        repeat (5) @(posedge net_clk);
        #1;
        n_checks++;
        if ({m_axis_valid, m_axis_last, m_axis_keep, m_axis_data} !== {1'b1, exp_q[0]})
            $display("FAIL overflow_hold: got %h want %h", {m_axis_valid, m_axis_last, m_axis_keep, m_axis_data}, {1'b1, exp_q[0]}); else n_pass++;
        n_checks++;
        if (stat_drop_ovf !== exp_stat(1))
            $display("FAIL overflow_stat: got %0d want %0d", stat_drop_ovf, exp_stat(1)); else n_pass++;
        m_axis_ready = 1'b1;
        wait_drain(exp_q.size(), 200);
        n_checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL overflow_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL overflow_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (stat_ok !== exp_stat(12)) $display("FAIL overflow_stat_ok: got %0d want %0d", stat_ok, exp_stat(12)); else n_pass++;
    endtask

    task automatic test_runt();
        exp_q.delete();
        got_q.delete();
        send_beat(hdr_beat(MY_MAC, ETH_TYPE_IPV4, 8'hA0), 16'h0FFF, 1'b1);
        n_checks++;
        if (dbg_state !== IDLE) $display("FAIL runt_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
        send_frame(MY_MAC, ETH_TYPE_IPV4, 1, 8'hA1, 1'b1);
        wait_drain(exp_q.size(), 50);
        n_checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL runt_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL runt_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (stat_drop_size !== exp_stat(2))
            $display("FAIL runt_stat: got %0d want %0d", stat_drop_size, exp_stat(2)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        got_q.delete();
        m_axis_ready = 1'b0;
        send_frame(MY_MAC, ETH_TYPE_IPV4, 2, 8'h70, 1'b0);
        send_beat(hdr_beat(MY_MAC, ETH_TYPE_IPV4, 8'h5A), 16'hFFFF, 1'b0);
        send_beat(body_beat(8'h5A, 1), 16'hFFFF, 1'b0);
        net_rst = 1'b1;
        @(posedge net_clk);
        #1;
        net_rst = 1'b0;
        n_checks++;
        if ({stat_ok, stat_drop_filter, stat_drop_size, stat_drop_ovf} !== '0)
            $display("FAIL rstmid_stats: got %h want 0", {stat_ok, stat_drop_filter, stat_drop_size, stat_drop_ovf}); else n_pass++;
        n_checks++;
        if (dbg_state !== IDLE) $display("FAIL rstmid_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
        m_axis_ready = 1'b1;
        repeat (20) @(posedge net_clk);
        #1;
        n_checks++;
        if (got_q.size() !== 0) $display("FAIL rstmid_no_output: got %0d beats want 0", got_q.size()); else n_pass++;
        // Tail of the cut frame is parsed as a new first beat and rejected by the filter.
        send_beat(body_beat(8'h5A, 2), 16'hFFFF, 1'b0);
        send_beat(body_beat(8'h5A, 3), 16'h00FF, 1'b1);
        send_frame(MY_MAC, ETH_TYPE_ARP, 3, 8'h80, 1'b1);
        wait_drain(exp_q.size(), 50);
        n_checks++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL rstmid_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rstmid_beat%0d: got %h want %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++;
        if (stat_ok !== exp_stat(1)) $display("FAIL rstmid_stat_ok: got %0d want %0d", stat_ok, exp_stat(1)); else n_pass++;
        n_checks++;
        if (stat_drop_filter !== exp_stat(1))
            $display("FAIL rstmid_stat_filter: got %0d want %0d", stat_drop_filter, exp_stat(1)); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_unicast();
        test_filter();
        test_oversize();
        test_overflow();
        test_runt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
